// File: rtl/otp_ctrl_buf_fill.sv
// Fill sequencer: streams Depth consecutive OTP words into the buffered-partition
// ECC register file, one outstanding read at a time, and reports done/error.
module otp_ctrl_buf_fill #(
    parameter int unsigned Width    = 64,
    parameter int unsigned Depth    = 128,
    parameter int unsigned OtpAw    = 11,
    parameter int unsigned BaseAddr = 0,
    localparam int unsigned Aw      = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             otp_req_o,
    input  logic             otp_gnt_i,
    output logic [OtpAw-1:0] otp_addr_o,
    input  logic             otp_rvalid_i,
    input  logic [Width-1:0] otp_rdata_i,
    input  logic             otp_err_i,
    output logic             wren_o,
    output logic [Aw-1:0]    waddr_o,
    output logic [Width-1:0] wdata_o
);

    if (Width != 64) begin : gen_width_chk
        $error("otp_ctrl_buf_fill: Width must be 64");
    end
    if (Depth < 1) begin : gen_depth_chk
        $error("otp_ctrl_buf_fill: Depth must be at least 1");
    end
    if ((64'(BaseAddr) + 64'(Depth)) > (64'd1 << OtpAw)) begin : gen_range_chk
        $error("otp_ctrl_buf_fill: BaseAddr + Depth exceeds the OTP address space");
    end

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [Aw-1:0]     cnt_q, cnt_d;
    logic              cnt_last;
    logic              req_d, busy_d, done_d, error_d;
    logic [OtpAw-1:0]  addr_d;
    logic              wr_fire;

    assign cnt_last = (cnt_q == Aw'(Depth - 1));

    // Next-state logic; any response outside WAIT is a protocol violation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (otp_rvalid_i) begin
                    state_d = StError;
                end else if (start_i) begin
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (otp_rvalid_i) begin
                    state_d = StError;
                end else if (otp_gnt_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (otp_rvalid_i) begin
                    if (otp_err_i) begin
                        state_d = StError;
                    end else if (cnt_last) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + Aw'(1);
                        state_d = StReq;
                    end
                end
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // Registered status/request outputs decoded from the next state.
    always_comb begin
        req_d   = (state_d == StReq);
        addr_d  = req_d ? (OtpAw'(BaseAddr) + OtpAw'(cnt_d)) : '0;
        busy_d  = req_d || (state_d == StWait);
        done_d  = (state_d == StDone);
        error_d = (state_d == StError);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            otp_req_o  <= 1'b0;
            otp_addr_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            otp_req_o  <= req_d;
            otp_addr_o <= addr_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            error_o    <= error_d;
        end
    end

    // Write port follows the response in the same cycle; zeroed when idle.
    assign wr_fire = (state_q == StWait) && otp_rvalid_i && !otp_err_i;
    assign wren_o  = wr_fire;
    assign waddr_o = wr_fire ? cnt_q : '0;
    assign wdata_o = wr_fire ? otp_rdata_i : '0;

endmodule

// File: tb/tb_otp_ctrl_buf_fill.sv
// Randomized bench for otp_ctrl_buf_fill: an OTP responder with a memory model
// checks request addresses, buffer writes, timing and error/reset behaviour.
module tb_otp_ctrl_buf_fill;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BASE  = 16;
    localparam int unsigned OAW   = 11;
    localparam int unsigned W     = 64;
    localparam int unsigned AW    = 2;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           busy_o, done_o, error_o;
    logic           otp_req_o;
    logic           gnt;
    logic [OAW-1:0] otp_addr_o;
    logic           rvalid;
    logic [W-1:0]   rdata;
    logic           rerr;
    logic           wren_o;
    logic [AW-1:0]  waddr_o;
    logic [W-1:0]   wdata_o;

    logic [W-1:0]   mem [0:2047];
    bit             wr_expect;
    int unsigned    cyc;
    int             n_checks;
    int             n_fail;

    otp_ctrl_buf_fill #(
        .Width   (W),
        .Depth   (DEPTH),
        .OtpAw   (OAW),
        .BaseAddr(BASE)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .otp_req_o   (otp_req_o),
        .otp_gnt_i   (gnt),
        .otp_addr_o  (otp_addr_o),
        .otp_rvalid_i(rvalid),
        .otp_rdata_i (rdata),
        .otp_err_i   (rerr),
        .wren_o      (wren_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Outside an expected write the port must be silent and zeroed.
    always @(negedge clk) begin
        #2;
        if (!wr_expect) begin
            check("no_wren", 64'(wren_o), 64'd0);
            check("wr_zero", 64'(waddr_o) | wdata_o, 64'd0);
        end
    end

    // One fill as seen by the OTP side; called at a negedge with the DUT idle or done.
    task automatic do_fill(input int err_word, input int stall_word, input int stall_n,
                           input bit rnd, input int abort_word, input int start_word,
                           input bit chk_time);
        int unsigned    t0;
        int             stalls, lat, wait_n;
        logic [OAW-1:0] a;
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check("done_clr", 64'(done_o), 64'd0);
        for (int k = 0; k < int'(DEPTH); k++) begin
            wait_n = 0;
            while (otp_req_o !== 1'b1 && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            check("req_seen", 64'(otp_req_o), 64'd1);
            if (otp_req_o !== 1'b1) return;
            check("busy", 64'(busy_o), 64'd1);
            a = OAW'(BASE + 32'(k));
            check("req_addr", 64'(otp_addr_o), 64'(a));
            stalls = (k == stall_word) ? stall_n : (rnd ? int'($urandom_range(0, 3)) : 0);
            for (int s = 0; s < stalls; s++) begin
                @(negedge clk);
                check("req_hold", 64'(otp_req_o), 64'd1);
                check("addr_hold", 64'(otp_addr_o), 64'(a));
            end
            if (k == start_word) start = 1'b1;
            gnt = 1'b1;
            @(negedge clk);
            gnt   = 1'b0;
            start = 1'b0;
            check("req_drop", 64'(otp_req_o), 64'd0);
            if (k == abort_word) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs", 64'({busy_o, done_o, error_o, otp_req_o, wren_o}), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            lat = rnd ? int'($urandom_range(0, 2)) : 0;
            repeat (lat) @(negedge clk);
            rvalid    = 1'b1;
            rerr      = (k == err_word);
            rdata     = mem[BASE + 32'(k)];
            wr_expect = (k != err_word);
            #1;
            check("wren", 64'(wren_o), (k == err_word) ? 64'd0 : 64'd1);
            if (k != err_word) begin
                check("waddr", 64'(waddr_o), 64'(k));
                check("wdata", wdata_o, mem[BASE + 32'(k)]);
            end
            if (chk_time && k == int'(DEPTH) - 1) check("done_early", 64'(done_o), 64'd0);
            @(negedge clk);
            rvalid    = 1'b0;
            rerr      = 1'b0;
            rdata     = '0;
            wr_expect = 1'b0;
            if (k == err_word) begin
                check("err_set", 64'(error_o), 64'd1);
                check("err_busy", 64'(busy_o), 64'd0);
                return;
            end
        end
        check("done", 64'(done_o), 64'd1);
        check("done_busy", 64'(busy_o), 64'd0);
        if (chk_time) check("fill_cycles", 64'(cyc - t0 - 1), 64'(2 * DEPTH));
    endtask

    task automatic check_reset_outs(input string tag);
        check(tag, 64'({busy_o, done_o, error_o, otp_req_o, wren_o}), 64'd0);
        check({tag, "_addr"}, 64'(otp_addr_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        gnt       = 1'b0;
        rvalid    = 1'b0;
        rerr      = 1'b0;
        rdata     = '0;
        start     = 1'b0;
        wr_expect = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
        for (int k = 0; k < int'(DEPTH); k++) mem[BASE + 32'(k)] = 64'hA5A5_0000_0000_0000 | 64'(k);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait fill with known data and cycle-exact completion.
        do_fill(-1, -1, 0, 1'b0, -1, -1, 1'b1);
        // Refill from DONE with a 5-cycle grant stall on word 2.
        do_fill(-1, 2, 5, 1'b0, -1, -1, 1'b0);
        // Refill with random stalls and a stray start mid-fill.
        do_fill(-1, -1, 0, 1'b1, -1, 1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < int'(DEPTH); k++) mem[BASE + 32'(k)] = {$urandom, $urandom};
            do_fill(-1, -1, 0, 1'b1, -1, int'($urandom_range(0, 4)), 1'b0);
        end

        // Read error on word 1 is terminal; start is then ignored.
        do_fill(1, -1, 0, 1'b1, -1, -1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("err_no_req", 64'(otp_req_o), 64'd0);
            check("err_sticky", 64'({error_o, busy_o, done_o}), 64'b100);
            @(negedge clk);
        end

        // Spurious response while idle.
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("reset2");
        rst_n = 1'b1;
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("spur_wren", 64'(wren_o), 64'd0);
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = '0;
        check("spur_err", 64'(error_o), 64'd1);
        check("spur_busy", 64'(busy_o), 64'd0);

        // Reset during WAIT of word 2, then a clean fill from the base address.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_fill(-1, -1, 0, 1'b1, 2, -1, 1'b0);
        check_reset_outs("abort_rst");
        @(negedge clk);
        do_fill(-1, -1, 0, 1'b0, -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otp_ctrl_buf_fill.md
Name: otp_ctrl_buf_fill

Overview:
- Upstream fill sequencer for the buffered-partition ECC register file.
- On a start pulse it reads Depth consecutive 64-bit words from the OTP macro interface, one outstanding request at a time.
- Each returned word is written into the ECC register file through its wren/addr/wdata write port.
- Reports completion or a sticky read error to the partition controller.

Parameters:
- Width, 64, data word width in bits; must be 64 (elaboration-time check).
- Depth, 128, number of words to fill; must be >= 1.
- OtpAw, 11, OTP word-address width.
- BaseAddr, 0, OTP word address of buffer word 0; BaseAddr + Depth <= 2**OtpAw (elaboration-time check).
- Aw, vbits(Depth), derived buffer address width (localparam).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle start pulse.
- busy_o  out  1  fill in progress.
- done_o  out  1  sticky: all Depth words written.
- error_o  out  1  sticky: OTP read error or protocol violation.
- otp_req_o  out  1  OTP read request.
- otp_gnt_i  in  1  OTP request grant.
- otp_addr_o  out  OtpAw  OTP word address.
- otp_rvalid_i  in  1  OTP read data valid.
- otp_rdata_i  in  Width  OTP read data.
- otp_err_i  in  1  error qualifier, valid with otp_rvalid_i.
- wren_o  out  1  buffer write enable.
- waddr_o  out  Aw  buffer write address.
- wdata_o  out  Width  buffer write data.

Behaviour:
- Reset:
  - All outputs 0; FSM goes to IDLE; word counter cnt = 0.
  - Reset asserted mid-fill aborts immediately. No further writes occur. done_o and error_o clear.
- FSM states: IDLE, REQ, WAIT, DONE, ERROR.
- IDLE:
  - start_i = 1 -> cnt := 0, go to REQ.
  - busy_o = 0.
- REQ:
  - otp_req_o = 1; otp_addr_o = BaseAddr + cnt, zero-extended to OtpAw.
  - req and addr are held stable until otp_gnt_i.
  - gnt -> go to WAIT. busy_o = 1.
- WAIT:
  - otp_req_o = 0; waits for otp_rvalid_i.
  - rvalid & !otp_err_i:
    - Same cycle, combinationally: wren_o = 1, waddr_o = cnt, wdata_o = otp_rdata_i.
    - The word is visible in the register file the following cycle.
    - If cnt == Depth-1 -> go to DONE; else cnt++ and go to REQ.
  - rvalid & otp_err_i -> go to ERROR with no write.
  - Minimum of 2 cycles per word: gnt cycle plus rvalid cycle. Zero-wait fill of Depth words takes 2*Depth cycles from start.
- DONE:
  - done_o = 1, busy_o = 0.
  - start_i -> clear done_o, cnt := 0, go to REQ (refill).
- ERROR:
  - Terminal until reset: error_o = 1, busy_o = 0.
  - No requests or writes; start_i is ignored.
- Protocol violation: otp_rvalid_i in any state other than WAIT -> go to ERROR (same cycle flag registered).
- start_i while in REQ or WAIT is ignored; it never restarts an active fill.
- wren_o is asserted only in WAIT with a valid, error-free response.
  - waddr_o < Depth always.
  - waddr_o and wdata_o are 0 whenever wren_o = 0.
- cnt is Aw bits. For Depth == 1, cnt is a constant 0 and waddr_o = 0.
- The following must be known (not X) out of reset: busy_o, done_o, error_o, otp_req_o, wren_o.

Test Plan:
- Depth = 4, BaseAddr = 16, gnt and rvalid each arrive 1 cycle after request, rdata = 0xA5A5_0000_0000_000k:
  - otp_addr_o sequence is 16, 17, 18, 19.
  - wren_o pulses with waddr 0..3 and matching data.
  - done_o rises 8 cycles after start; busy_o then falls.
- Grant stall: otp_gnt_i held low for 5 cycles on word 2 -> otp_req_o and otp_addr_o = BaseAddr+2 stay stable for all 6 cycles; fill completes normally.
- otp_err_i = 1 with rvalid on word 1:
  - Word 0 is written; no write occurs for word 1.
  - error_o = 1 and stays high.
  - A subsequent start_i produces no otp_req_o.
- Spurious otp_rvalid_i in IDLE -> error_o = 1 the next cycle; no wren_o.
- Reset asserted during WAIT of word 2 -> all outputs 0 immediately. A new start after reset refetches from BaseAddr with waddr 0.
- In DONE, pulse start_i -> done_o clears and a full refill repeats. start_i pulsed during the refill is ignored; the addresses stay monotonic.
